// File: rtl/aibio_outclk_phsel_ctrl_if.sv
// Request/status bundle between a phase-select requester and the output-clock phase sequencer.
// Member names are seen from the sequencer side: i_* are its inputs, o_* its outputs.
interface aibio_outclk_phsel_ctrl_if;
  logic       i_req_vld;
  logic [3:0] i_phsel_tgt;
  logic       o_req_rdy;
  logic [3:0] o_clksel;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_req_vld, i_phsel_tgt,
    input  o_req_rdy, o_clksel, o_busy, o_done
  );

  modport slave (
    input  i_req_vld, i_phsel_tgt,
    output o_req_rdy, o_clksel, o_busy, o_done
  );
endinterface

// File: rtl/aibio_outclk_phsel_ctrl.sv
// Walks the DLL 16:1 output-clock mux select one phase at a time along the shorter circular
// path, holding every code SETTLE_CYC cycles so the mux output never jumps more than one step.
module aibio_outclk_phsel_ctrl #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter logic [3:0]  RESET_SEL  = 4'd0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  aibio_outclk_phsel_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYC - 1);

  state_t     r_state;
  logic [3:0] r_clksel;
  logic [3:0] r_tgt;
  logic [7:0] r_cnt;
  logic       r_done;

  // One step toward tgt; a distance of exactly 8 resolves upward.
  function automatic logic [3:0] stepToward(input logic [3:0] cur, input logic [3:0] tgt);
    logic [3:0] d;
    d = tgt - cur;
    if (d == 4'd0)      return cur;
    else if (d <= 4'd8) return cur + 4'd1;
    else                return cur - 4'd1;
  endfunction

  // A zero-step request passes through one empty settle cycle so o_done lands one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_clksel <= RESET_SEL;
      r_tgt    <= RESET_SEL;
      r_cnt    <= 8'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_req_vld) begin
            r_tgt   <= bus.i_phsel_tgt;
            r_state <= SETTLE;
            if (bus.i_phsel_tgt != r_clksel) begin
              r_clksel <= stepToward(r_clksel, bus.i_phsel_tgt);
              r_cnt    <= RELOAD;
            end else begin
              r_cnt    <= 8'd0;
            end
          end
        end
        SETTLE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (r_clksel != r_tgt) begin
            r_clksel <= stepToward(r_clksel, r_tgt);
            r_cnt    <= RELOAD;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_clksel  = r_clksel;
  assign bus.o_done    = r_done;
  assign bus.o_req_rdy = (r_state == IDLE);
  assign bus.o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_aibio_outclk_phsel_ctrl.sv
// Bench for aibio_outclk_phsel_ctrl: directed scenarios with literal expectations, then random
// requests and reset pulses, all checked every cycle against a move-level timeline model.
module tb_aibio_outclk_phsel_ctrl;

  localparam int S = 4;
  localparam logic [3:0] RSEL = 4'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   sbOn = 1'b0;

  aibio_outclk_phsel_ctrl_if bus ();

  aibio_outclk_phsel_ctrl #(
    .SETTLE_CYC (S),
    .RESET_SEL  (RSEL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       rdy;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{sel: RSEL, rdy: 1'b1, busy: 1'b0, done: 1'b0};

  function automatic exp_t idleExp(input logic [3:0] s);
    exp_t e;
    e.sel = s; e.rdy = 1'b1; e.busy = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  function automatic exp_t busyExp(input int s, input logic dn);
    exp_t e;
    e.sel = 4'(s); e.rdy = 1'b0; e.busy = 1'b1; e.done = dn;
    return e;
  endfunction

  // Expand one accepted request into the per-cycle outputs that follow the accept edge.
  task automatic planMove(input int c, input int t);
    int d, n, dir;
    d = (t - c + 16) % 16;
    if (d == 0) begin
      q.push_back(busyExp(c, 1'b0));
      q.push_back(busyExp(c, 1'b1));
    end else begin
      n   = (d <= 8) ? d : 16 - d;
      dir = (d <= 8) ? 1 : -1;
      for (int i = 1; i <= n; i++)
        for (int j = 0; j < S; j++)
          q.push_back(busyExp((c + dir * i + 16) % 16, 1'b0));
      q.push_back(busyExp(t, 1'b1));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur = idleExp(RSEL);
    end else begin
      if (cur.rdy && bus.i_req_vld)
        planMove(int'(cur.sel), int'(bus.i_phsel_tgt));
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idleExp(cur.sel);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbOn) begin
      checkOutput("sb_clksel", int'(bus.o_clksel),  int'(cur.sel));
      checkOutput("sb_rdy",    int'(bus.o_req_rdy), int'(cur.rdy));
      checkOutput("sb_busy",   int'(bus.o_busy),    int'(cur.busy));
      checkOutput("sb_done",   int'(bus.o_done),    int'(cur.done));
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] t);
    bus.i_req_vld   = v;
    bus.i_phsel_tgt = t;
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(name, 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit saw13;
    applyStimulus(1'b0, 4'd0);
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    sbOn = 1'b1;
    rst_n = 1'b1;
    checkOutput("t1_clksel", int'(bus.o_clksel), 0);
    checkOutput("t1_rdy",    int'(bus.o_req_rdy), 1);
    checkOutput("t1_busy",   int'(bus.o_busy), 0);
    checkOutput("t1_done",   int'(bus.o_done), 0);

    $display("[TB] up move 0->3 with held request for 5");
    applyStimulus(1'b1, 4'd3);
    @(negedge clk);
    checkOutput("t2_sel_n",  int'(bus.o_clksel), 1);
    checkOutput("t2_rdy_n",  int'(bus.o_req_rdy), 0);
    applyStimulus(1'b1, 4'd5);
    repeat (4) @(negedge clk);
    checkOutput("t2_sel_n4", int'(bus.o_clksel), 2);
    repeat (4) @(negedge clk);
    checkOutput("t2_sel_n8", int'(bus.o_clksel), 3);
    checkOutput("t2_done_n8", int'(bus.o_done), 0);
    repeat (4) @(negedge clk);
    checkOutput("t2_done_n12", int'(bus.o_done), 1);
    checkOutput("t2_sel_n12",  int'(bus.o_clksel), 3);
    @(negedge clk);
    checkOutput("t2_done_n13", int'(bus.o_done), 0);
    checkOutput("t2_rdy_n13",  int'(bus.o_req_rdy), 1);
    @(negedge clk);
    checkOutput("t6_held_sel", int'(bus.o_clksel), 4);
    applyStimulus(1'b0, 4'd0);
    waitIdle("t6_held_timeout");
    checkOutput("t6_held_final", int'(bus.o_clksel), 5);

    $display("[TB] wrap down/up");
    applyStimulus(1'b1, 4'd14);
    @(negedge clk);
    checkOutput("t3_down_first", int'(bus.o_clksel), 4);
    applyStimulus(1'b0, 4'd0);
    waitIdle("t3_to14_timeout");
    checkOutput("t3_at14", int'(bus.o_clksel), 14);
    applyStimulus(1'b1, 4'd1);
    @(negedge clk);
    checkOutput("t3_wrap_first", int'(bus.o_clksel), 15);
    applyStimulus(1'b0, 4'd0);
    saw13 = 1'b0;
    for (int i = 0; i < 200 && !bus.o_req_rdy; i++) begin
      @(negedge clk);
      if (bus.o_clksel == 4'd13) saw13 = 1'b1;
    end
    checkOutput("t3_no13", int'(saw13), 0);
    checkOutput("t3_final", int'(bus.o_clksel), 1);

    $display("[TB] tie goes up, single step down");
    applyStimulus(1'b1, 4'd0);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0);
    waitIdle("t4_to0_timeout");
    applyStimulus(1'b1, 4'd8);
    @(negedge clk);
    checkOutput("t4_tie_up", int'(bus.o_clksel), 1);
    applyStimulus(1'b0, 4'd0);
    waitIdle("t4_to8_timeout");
    checkOutput("t4_at8", int'(bus.o_clksel), 8);
    applyStimulus(1'b1, 4'd7);
    @(negedge clk);
    checkOutput("t4_down", int'(bus.o_clksel), 7);
    applyStimulus(1'b0, 4'd0);
    waitIdle("t4_to7_timeout");

    $display("[TB] same target");
    applyStimulus(1'b1, 4'd7);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0);
    checkOutput("t5_sel",    int'(bus.o_clksel), 7);
    checkOutput("t5_done0",  int'(bus.o_done), 0);
    checkOutput("t5_busy",   int'(bus.o_busy), 1);
    @(negedge clk);
    checkOutput("t5_done1",  int'(bus.o_done), 1);
    @(negedge clk);
    checkOutput("t5_done2",  int'(bus.o_done), 0);
    checkOutput("t5_rdy",    int'(bus.o_req_rdy), 1);

    $display("[TB] reset mid-move");
    applyStimulus(1'b1, 4'd12);
    @(negedge clk);
    applyStimulus(1'b0, 4'd0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_sel",  int'(bus.o_clksel), 0);
    checkOutput("t6_rst_busy", int'(bus.o_busy), 0);
    checkOutput("t6_rst_done", int'(bus.o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random requests");
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) begin
        applyStimulus(1'b0, 4'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 4'd0);
    waitIdle("final_timeout");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
